// File: rtl/arashi_mem_wr.sv
// Write-back path: round-robin arbiter over per-thread write requests
// into a circular FIFO, drained to the cache through a valid/ready port.
`timescale 1ns/1ps
module arashi_mem_wr #(
  parameter int  DATA_WIDTH       = 32,
  parameter int  THREAD_NUM_WIDTH = 2,
  parameter int  MEM_WIDTH        = 4,
  localparam int THREAD_NUM       = 1 << THREAD_NUM_WIDTH
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [THREAD_NUM-1:0]            w_ena,
  input  logic [DATA_WIDTH*THREAD_NUM-1:0] data_in,
  output logic [THREAD_NUM-1:0]            w_ready,
  output logic [DATA_WIDTH-1:0]            mem2cache,
  output logic [THREAD_NUM_WIDTH-1:0]      mem2cache_tid,
  output logic                             mem2cache_vld,
  input  logic                             cache_ready,
  output logic [MEM_WIDTH-1:0]             backlog,
  output logic                             mem_full
);

  localparam int DEPTH = 1 << MEM_WIDTH;
  localparam logic [MEM_WIDTH-1:0] NO_MORE = '1;

  logic [DATA_WIDTH-1:0]       r_mem_data [DEPTH];
  logic [THREAD_NUM_WIDTH-1:0] r_mem_tid  [DEPTH];

  logic [MEM_WIDTH-1:0]        r_wptr;
  logic [MEM_WIDTH-1:0]        r_rptr;
  logic [THREAD_NUM_WIDTH-1:0] r_last;
  logic [THREAD_NUM-1:0]       r_w_ready;
  logic [DATA_WIDTH-1:0]       r_out_data;
  logic [THREAD_NUM_WIDTH-1:0] r_out_tid;
  logic                        r_out_vld;

  logic [THREAD_NUM-1:0]       w_elig;
  logic [THREAD_NUM_WIDTH-1:0] w_idx;
  logic [THREAD_NUM_WIDTH-1:0] w_gnt_id;
  logic                        w_gnt_vld;
  logic                        w_load;
  logic [MEM_WIDTH-1:0]        w_backlog;
  logic                        w_full;

  assign w_backlog = r_wptr - r_rptr;
  assign w_full    = (w_backlog == NO_MORE);

  // The thread granted last edge still holds its request this cycle; mask it.
  assign w_elig = w_ena & ~r_w_ready;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    for (int k = 1; k <= THREAD_NUM; k++) begin
      w_idx = r_last + THREAD_NUM_WIDTH'(k);
      if (!w_gnt_vld && w_elig[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_idx;
      end
    end
    if (w_full) w_gnt_vld = 1'b0;
  end

  assign w_load = (!r_out_vld || cache_ready) && (w_backlog != '0);

  always_ff @(posedge clk) begin
    if (w_gnt_vld) begin
      r_mem_data[r_wptr] <= data_in[w_gnt_id*DATA_WIDTH +: DATA_WIDTH];
      r_mem_tid[r_wptr]  <= w_gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr    <= '0;
      r_last    <= THREAD_NUM_WIDTH'(THREAD_NUM - 1);
      r_w_ready <= '0;
    end else if (w_gnt_vld) begin
      r_wptr    <= r_wptr + 1'b1;
      r_last    <= w_gnt_id;
      r_w_ready <= THREAD_NUM'(1) << w_gnt_id;
    end else begin
      r_w_ready <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rptr     <= '0;
      r_out_data <= '0;
      r_out_tid  <= '0;
      r_out_vld  <= 1'b0;
    end else if (w_load) begin
      r_out_data <= r_mem_data[r_rptr];
      r_out_tid  <= r_mem_tid[r_rptr];
      r_rptr     <= r_rptr + 1'b1;
      r_out_vld  <= 1'b1;
    end else if (r_out_vld && cache_ready) begin
      r_out_vld  <= 1'b0;
    end
  end

  assign w_ready       = r_w_ready;
  assign mem2cache     = r_out_data;
  assign mem2cache_tid = r_out_tid;
  assign mem2cache_vld = r_out_vld;
  assign backlog       = w_backlog;
  assign mem_full      = w_full;

endmodule

// File: tb/tb_arashi_mem_wr.sv
// Bench for arashi_mem_wr: queue-level model compared every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_arashi_mem_wr;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [3:0]   w_ena = '0;
  logic [127:0] data_in = '0;
  logic [3:0]   w_ready;
  logic [31:0]  mem2cache;
  logic [1:0]   mem2cache_tid;
  logic         mem2cache_vld;
  logic         cache_ready = 1'b0;
  logic [3:0]   backlog;
  logic         mem_full;

  arashi_mem_wr dut (
    .clk(clk), .rstn(rstn), .w_ena(w_ena), .data_in(data_in),
    .w_ready(w_ready), .mem2cache(mem2cache),
    .mem2cache_tid(mem2cache_tid), .mem2cache_vld(mem2cache_vld),
    .cache_ready(cache_ready), .backlog(backlog), .mem_full(mem_full)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue of accepted words, output slot separate.
  typedef struct {
    logic [1:0]  tid;
    logic [31:0] d;
  } w_t;

  w_t         q[$];
  w_t         m_out;
  logic       m_vld;
  logic [3:0] m_wready;
  int         m_last;
  int         n_acc;
  int         dut_emit;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      m_out    = '{2'd0, 32'd0};
      m_vld    = 1'b0;
      m_wready = '0;
      m_last   = 3;
      n_acc    = 0;
      dut_emit = 0;
    end else begin
      logic [3:0] elig;
      int g;
      if (mem2cache_vld && cache_ready) dut_emit++;
      elig = w_ena & ~m_wready;
      g = -1;
      if (elig != 0 && q.size() < 15)
        for (int k = 1; k <= 4; k++)
          if (g < 0 && elig[(m_last + k) % 4]) g = (m_last + k) % 4;
      if ((!m_vld || cache_ready) && q.size() > 0) begin
        m_out = q.pop_front();
        m_vld = 1'b1;
      end else if (m_vld && cache_ready) begin
        m_vld = 1'b0;
      end
      if (g >= 0) begin
        q.push_back('{2'(g), data_in[g*32 +: 32]});
        m_last   = g;
        m_wready = 4'(1 << g);
        n_acc++;
      end else begin
        m_wready = '0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rstn) begin
      chk("m_w_ready", 64'(w_ready), 64'(m_wready));
      chk("m_vld", 64'(mem2cache_vld), 64'(m_vld));
      chk("m_backlog", 64'(backlog), 64'(q.size()));
      chk("m_full", 64'(mem_full), 64'(q.size() == 15));
      if (m_vld) begin
        chk("m_data", 64'(mem2cache), 64'(m_out.d));
        chk("m_tid", 64'(mem2cache_tid), 64'(m_out.tid));
      end
    end
  end

  int  cyc = 0;
  bit  auto_data = 1'b0;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (auto_data)
      for (int i = 0; i < 4; i++)
        data_in[i*32 +: 32] = {8'(i), 24'(cyc)};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    w_ena = '0;
    step();
    rstn = 1'b1;
  endtask

  logic [3:0] exp_g [8];
  int cnt;

  initial begin
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0001;
    exp_g[2] = 4'b0010; exp_g[3] = 4'b0100;
    exp_g[4] = 4'b1000; exp_g[5] = 4'b0001;
    exp_g[6] = 4'b0010; exp_g[7] = 4'b0100;

    repeat (2) step();
    rstn = 1'b1;
    chk("rst_vld", 64'(mem2cache_vld), 64'd0);
    chk("rst_backlog", 64'(backlog), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);

    // single write from thread 2
    cache_ready = 1'b1;
    data_in[2*32 +: 32] = 32'hA5A5_0001;
    w_ena = 4'b0100;
    step();
    chk("t2_w_ready", 64'(w_ready), 64'b0100);
    chk("t2_vld_early", 64'(mem2cache_vld), 64'd0);
    w_ena = '0;
    step();
    chk("t2_w_ready_drop", 64'(w_ready), 64'd0);
    chk("t2_vld", 64'(mem2cache_vld), 64'd1);
    chk("t2_data", 64'(mem2cache), 64'h0000_0000_A5A5_0001);
    chk("t2_tid", 64'(mem2cache_tid), 64'd2);
    step();
    chk("t2_vld_done", 64'(mem2cache_vld), 64'd0);

    // round-robin, all threads requesting; last grant was thread 2
    auto_data = 1'b1;
    w_ena = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3_grant", 64'(w_ready), 64'(exp_g[i]));
    end

    // async reset mid-traffic, between edges
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t1_w_ready", 64'(w_ready), 64'd0);
    chk("t1_vld", 64'(mem2cache_vld), 64'd0);
    chk("t1_data", 64'(mem2cache), 64'd0);
    chk("t1_tid", 64'(mem2cache_tid), 64'd0);
    chk("t1_backlog", 64'(backlog), 64'd0);
    step();
    w_ena = '0;
    rstn = 1'b1;

    // fill: 15 in FIFO plus one in the output register
    cache_ready = 1'b0;
    w_ena = 4'b1111;
    cnt = 0;
    repeat (25) begin
      step();
      if (w_ready != 0) cnt++;
    end
    chk("t4_accepts", 64'(cnt), 64'd16);
    chk("t4_backlog", 64'(backlog), 64'd15);
    chk("t4_full", 64'(mem_full), 64'd1);
    chk("t4_w_ready", 64'(w_ready), 64'd0);
    chk("t4_vld", 64'(mem2cache_vld), 64'd1);
    w_ena = '0;
    cache_ready = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("t4_drain", 64'(backlog), 64'(15 - k));
    end
    chk("t4_last_vld", 64'(mem2cache_vld), 64'd1);
    step();
    chk("t4_empty_vld", 64'(mem2cache_vld), 64'd0);
    chk("t4_emitted", 64'(dut_emit), 64'd16);

    // random backpressure
    do_reset();
    repeat (300) begin
      step();
      w_ena = 4'($urandom);
      cache_ready = 1'($urandom_range(0, 1));
    end
    w_ena = '0;
    cache_ready = 1'b1;
    repeat (40) step();
    chk("t5_emit_eq_acc", 64'(dut_emit), 64'(n_acc));
    chk("t5_backlog", 64'(backlog), 64'd0);

    // stream 40 words, pointers wrap twice
    do_reset();
    cache_ready = 1'b1;
    w_ena = 4'b0011;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 40; i++) begin
      step();
      if (w_ready != 0) cnt++;
    end
    w_ena = '0;
    chk("t6_accepts", 64'(cnt), 64'd40);
    repeat (20) step();
    chk("t6_emitted", 64'(dut_emit), 64'd40);
    chk("t6_backlog", 64'(backlog), 64'd0);
    chk("t6_vld", 64'(mem2cache_vld), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
